// File: rtl/sd_cmd_arbiter_pkg.sv
// rtl/sd_cmd_arbiter_pkg.sv - shared types, encodings and defaults for the SD command arbiter
package sd_cmd_arbiter_pkg;

  // One-hot arbiter states
  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_ISSUE    = 5'b00010,
    ST_WAIT_ACC = 5'b00100,
    ST_RUN      = 5'b01000,
    ST_DONE     = 5'b10000
  } arb_state_e;

  // Requester identities, also the encoding of the owner output
  localparam logic OWNER_SW = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  // Default timing limits
  localparam int unsigned TMO_W_DEF   = 16;
  localparam logic [15:0] TMO_MAX_DEF = 16'hFFFF;
  localparam int unsigned ACC_MAX_DEF = 8;

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last
  function automatic logic rr_pick(input logic sw_req, input logic dm_req, input logic last_grant);
    logic win;
    if (sw_req && dm_req) begin
      win = ~last_grant;
    end else if (dm_req) begin
      win = OWNER_DM;
    end else begin
      win = OWNER_SW;
    end
    return win;
  endfunction

endpackage

// File: rtl/sd_cmd_arbiter_if.sv
// rtl/sd_cmd_arbiter_if.sv - requester, engine and status signals around the command arbiter
interface sd_cmd_arbiter_if;

  // Software register requester
  logic        sw_req;
  logic [31:0] sw_arg;
  logic [15:0] sw_set;
  logic        sw_ack;
  logic        sw_done;

  // Data master requester
  logic        dm_req;
  logic [31:0] dm_arg;
  logic [15:0] dm_set;
  logic        dm_ack;
  logic        dm_done;

  // Command engine
  logic        cmd_start;
  logic [31:0] cmd_arg;
  logic [15:0] cmd_set;
  logic        cmd_busy;
  logic        cmd_err;

  // Status
  logic        done_err;
  logic        tmo_err;
  logic        tmo_clr;
  logic        owner;
  logic        arb_busy;

  // Arbiter side
  modport slave (
    input  sw_req, sw_arg, sw_set,
    input  dm_req, dm_arg, dm_set,
    input  cmd_busy, cmd_err, tmo_clr,
    output sw_ack, sw_done, dm_ack, dm_done,
    output cmd_start, cmd_arg, cmd_set,
    output done_err, tmo_err, owner, arb_busy
  );

  // Requesters and engine side
  modport master (
    output sw_req, sw_arg, sw_set,
    output dm_req, dm_arg, dm_set,
    output cmd_busy, cmd_err, tmo_clr,
    input  sw_ack, sw_done, dm_ack, dm_done,
    input  cmd_start, cmd_arg, cmd_set,
    input  done_err, tmo_err, owner, arb_busy
  );

endinterface

// File: rtl/sd_cmd_arbiter_sat_counter.sv
// rtl/sd_cmd_arbiter_sat_counter.sv - saturating up-counter with clear and limit-hit flag
module sd_cmd_arbiter_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] max,
  output logic         hit
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Once the limit is reached the count parks there, so it can never wrap
  assign hit = (cnt_q >= max);

  // Next count: clear has priority, then increment while below the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !hit) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_cmd_arbiter.sv
// rtl/sd_cmd_arbiter.sv - shares the SD command engine between software and the data master
module sd_cmd_arbiter
  import sd_cmd_arbiter_pkg::*;
#(
  parameter int unsigned      TMO_W   = TMO_W_DEF,
  parameter logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_MAX_DEF),
  parameter int unsigned      ACC_MAX = ACC_MAX_DEF
) (
  input logic             clk,
  input logic             rst,
  sd_cmd_arbiter_if.slave bus
);

  // Both counters fire on the edge that completes the N-th cycle in their state,
  // so the hit threshold is one below the cycle budget.
  localparam int unsigned      ACC_W   = $clog2(ACC_MAX + 1);
  localparam logic [ACC_W-1:0] ACC_LIM = ACC_W'(ACC_MAX - 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_MAX - TMO_W'(1);

  arb_state_e  state_q,     state_d;
  logic        owner_q,     owner_d;
  logic [31:0] cmd_arg_q,   cmd_arg_d;
  logic [15:0] cmd_set_q,   cmd_set_d;
  logic        sw_ack_q,    sw_ack_d;
  logic        dm_ack_q,    dm_ack_d;
  logic        sw_done_q,   sw_done_d;
  logic        dm_done_q,   dm_done_d;
  logic        cmd_start_q, cmd_start_d;
  logic        done_err_q,  done_err_d;
  logic        tmo_err_q,   tmo_err_d;
  logic        arb_busy_q,  arb_busy_d;

  logic win;
  logic finish;
  logic finish_err;
  logic acc_en, acc_clr, acc_hit;
  logic tmo_en, tmo_clr_cnt, tmo_hit;

  // owner doubles as the last-grant memory for round-robin; both reset to SW
  assign win = rr_pick(bus.sw_req, bus.dm_req, owner_q);

  // Each counter only runs in its own state and is held clear everywhere else
  assign acc_en      = (state_q == ST_WAIT_ACC);
  assign acc_clr     = (state_q != ST_WAIT_ACC);
  assign tmo_en      = (state_q == ST_RUN);
  assign tmo_clr_cnt = (state_q != ST_RUN);

  sd_cmd_arbiter_sat_counter #(.W(ACC_W)) u_acc_cnt (
    .clk (clk),
    .rst (rst),
    .en  (acc_en),
    .clr (acc_clr),
    .max (ACC_LIM),
    .hit (acc_hit)
  );

  sd_cmd_arbiter_sat_counter #(.W(TMO_W)) u_tmo_cnt (
    .clk (clk),
    .rst (rst),
    .en  (tmo_en),
    .clr (tmo_clr_cnt),
    .max (TMO_LIM),
    .hit (tmo_hit)
  );

  // Next-state and registered-output logic for the grant/issue/track/report sequence
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cmd_arg_d   = cmd_arg_q;
    cmd_set_d   = cmd_set_q;
    sw_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    sw_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    cmd_start_d = 1'b0;
    done_err_d  = 1'b0;
    finish      = 1'b0;
    finish_err  = 1'b0;
    tmo_err_d   = bus.tmo_clr ? 1'b0 : tmo_err_q;

    unique case (state_q)
      ST_IDLE: begin
        // An engine still busy from elsewhere blocks any grant
        if (!bus.cmd_busy && (bus.sw_req || bus.dm_req)) begin
          owner_d = win;
          if (win == OWNER_DM) begin
            cmd_arg_d = bus.dm_arg;
            cmd_set_d = bus.dm_set;
            dm_ack_d  = 1'b1;
          end else begin
            cmd_arg_d = bus.sw_arg;
            cmd_set_d = bus.sw_set;
            sw_ack_d  = 1'b1;
          end
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cmd_start_d = 1'b1;
        state_d     = ST_WAIT_ACC;
      end

      ST_WAIT_ACC: begin
        if (bus.cmd_busy) begin
          state_d = ST_RUN;
        end else if (acc_hit) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end
      end

      ST_RUN: begin
        if (!bus.cmd_busy) begin
          finish     = 1'b1;
          finish_err = bus.cmd_err;
        end else if (tmo_hit) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          tmo_err_d  = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The done pulse is registered on entry to DONE so it is visible during the DONE cycle
    if (finish) begin
      state_d    = ST_DONE;
      done_err_d = finish_err;
      sw_done_d  = (owner_q == OWNER_SW);
      dm_done_d  = (owner_q == OWNER_DM);
    end

    arb_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any command in flight without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_SW;
      cmd_arg_q   <= '0;
      cmd_set_q   <= '0;
      sw_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      sw_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      cmd_start_q <= 1'b0;
      done_err_q  <= 1'b0;
      tmo_err_q   <= 1'b0;
      arb_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_arg_q   <= cmd_arg_d;
      cmd_set_q   <= cmd_set_d;
      sw_ack_q    <= sw_ack_d;
      dm_ack_q    <= dm_ack_d;
      sw_done_q   <= sw_done_d;
      dm_done_q   <= dm_done_d;
      cmd_start_q <= cmd_start_d;
      done_err_q  <= done_err_d;
      tmo_err_q   <= tmo_err_d;
      arb_busy_q  <= arb_busy_d;
    end
  end

  assign bus.sw_ack    = sw_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.sw_done   = sw_done_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.cmd_start = cmd_start_q;
  assign bus.cmd_arg   = cmd_arg_q;
  assign bus.cmd_set   = cmd_set_q;
  assign bus.done_err  = done_err_q;
  assign bus.tmo_err   = tmo_err_q;
  assign bus.owner     = owner_q;
  assign bus.arb_busy  = arb_busy_q;

endmodule
